// File: rtl/data_peak_pkg.sv
// Shared types and constants for the data-peak capture path.
package data_peak_pkg;

  localparam int DP_SAMPLE_W         = 8;
  localparam int DP_SAMPLES_PER_WORD = 4;
  localparam int DP_WORD_W           = 32;

  typedef enum logic [1:0] {
    DP_IDLE    = 2'd0,
    DP_CAPTURE = 2'd1,
    DP_READOUT = 2'd2
  } dp_state_e;

  // Byte 0 is the oldest sample, held in the top lane of the word.
  function automatic logic [DP_SAMPLE_W-1:0] dp_byte_sel(
    input logic [DP_WORD_W-1:0] word,
    input logic [1:0]           idx
  );
    logic [DP_SAMPLE_W-1:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/data_peak_word_ram.sv
// Simple dual-port word RAM: one write port, one registered read port.
module data_peak_word_ram
  import data_peak_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [AW-1:0]        i_waddr,
  input  logic [DP_WORD_W-1:0] i_wdata,
  input  logic [AW-1:0]        i_raddr,
  output logic [DP_WORD_W-1:0] o_rdata
);

  logic [DP_WORD_W-1:0] r_mem [DEPTH];
  logic [DP_WORD_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_peak_stage2_buffer.sv
// Trigger-initiated burst capture buffer with byte-wide registered readout.
// Optional: DATA_PEAK_S2_RETRIGGER_EN lets a trigger during READOUT restart capture.
module data_peak_stage2_buffer
  import data_peak_pkg::*;
#(
  parameter int CAPTURE_WORDS = 16
) (
  input  logic                   SysClk,
  input  logic                   Reset_n,
  input  logic [DP_WORD_W-1:0]   DataIn,
  input  logic                   FastTrigger,
  input  logic                   DataRead,
  output logic                   DataAvailable,
  output logic                   DataValid,
  output logic [DP_SAMPLE_W-1:0] DataOut
);

  localparam int WAW = $clog2(CAPTURE_WORDS);
  localparam int BIW = WAW + 2;
  localparam logic [WAW-1:0] LAST_WORD = WAW'(CAPTURE_WORDS - 1);
  localparam logic [BIW-1:0] LAST_IDX  = BIW'(DP_SAMPLES_PER_WORD * CAPTURE_WORDS - 1);

  dp_state_e              r_state;
  logic [WAW-1:0]         r_wr_ptr;
  logic [BIW-1:0]         r_rd_idx;
  logic                   r_avail;
  logic                   r_valid;
  logic [DP_SAMPLE_W-1:0] r_dout;

  logic                   w_accept;
  logic                   w_last;
  logic                   w_retrig;
  logic                   w_we;
  logic [BIW-1:0]         w_rd_idx_next;
  logic [DP_WORD_W-1:0]   w_ram_q;

  always_comb begin
    w_accept = (r_state == DP_READOUT) && r_avail && DataRead;
    w_last   = (r_rd_idx == LAST_IDX);
`ifdef DATA_PEAK_S2_RETRIGGER_EN
    // A trigger coinciding with the final accepted byte is ignored.
    w_retrig = (r_state == DP_READOUT) && FastTrigger && !(w_accept && w_last);
`else
    w_retrig = 1'b0;
`endif
    w_we = ((r_state == DP_IDLE) && FastTrigger) || (r_state == DP_CAPTURE) || w_retrig;

    w_rd_idx_next = r_rd_idx;
    if (w_retrig) begin
      w_rd_idx_next = '0;
    end else if (w_accept) begin
      w_rd_idx_next = w_last ? '0 : r_rd_idx + 1'b1;
    end
  end

  // Read address follows the next byte index so the RAM output register
  // always holds the word of the byte about to be served.
  data_peak_word_ram #(
    .DEPTH (CAPTURE_WORDS),
    .AW    (WAW)
  ) u_ram (
    .i_clk   (SysClk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (DataIn),
    .i_raddr (w_rd_idx_next[BIW-1:2]),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge SysClk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= DP_IDLE;
      r_wr_ptr <= '0;
      r_rd_idx <= '0;
      r_avail  <= 1'b0;
      r_valid  <= 1'b0;
      r_dout   <= '0;
    end else begin
      r_valid  <= 1'b0;
      r_rd_idx <= w_rd_idx_next;
      unique case (r_state)
        DP_IDLE: begin
          if (FastTrigger) begin
            r_state  <= DP_CAPTURE;
            r_wr_ptr <= r_wr_ptr + 1'b1;
          end
        end
        DP_CAPTURE: begin
          if (r_wr_ptr == LAST_WORD) begin
            r_wr_ptr <= '0;
            r_state  <= DP_READOUT;
          end else begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
          end
        end
        DP_READOUT: begin
          // First READOUT cycle primes the RAM read register before raising availability.
          if (w_retrig) begin
            r_state  <= DP_CAPTURE;
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_avail  <= 1'b0;
          end else if (!r_avail) begin
            r_avail <= 1'b1;
          end else if (w_accept) begin
            r_dout  <= dp_byte_sel(w_ram_q, r_rd_idx[1:0]);
            r_valid <= 1'b1;
            if (w_last) begin
              r_avail <= 1'b0;
              r_state <= DP_IDLE;
            end
          end
        end
        default: r_state <= DP_IDLE;
      endcase
    end
  end

  assign DataAvailable = r_avail;
  assign DataValid     = r_valid;
  assign DataOut       = r_dout;

endmodule

// File: tb/tb_data_peak_stage2_buffer.sv
// Self-checking bench for data_peak_stage2_buffer against a byte-queue reference model.
module tb_data_peak_stage2_buffer;

  localparam int N  = 16;
  localparam int NB = 4 * N;

  logic        SysClk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [31:0] DataIn = '0;
  logic        FastTrigger = 1'b0;
  logic        DataRead = 1'b0;
  logic        DataAvailable;
  logic        DataValid;
  logic [7:0]  DataOut;

  data_peak_stage2_buffer #(.CAPTURE_WORDS(N)) dut (
    .SysClk        (SysClk),
    .Reset_n       (Reset_n),
    .DataIn        (DataIn),
    .FastTrigger   (FastTrigger),
    .DataRead      (DataRead),
    .DataAvailable (DataAvailable),
    .DataValid     (DataValid),
    .DataOut       (DataOut)
  );

  always #5 SysClk = ~SysClk;

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of captured-but-unread bytes plus the trigger edge time.
  bit         m_busy;
  int         m_T;
  int         e;
  logic [7:0] q[$];
  bit         m_avail;
  bit         m_valid;
  logic [7:0] m_out;
  logic [7:0] got[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_avail = 0; m_valid = 0; m_out = '0; q.delete();
  endtask

  task automatic push_word(input logic [31:0] w);
    q.push_back(w[31:24]); q.push_back(w[23:16]);
    q.push_back(w[15:8]);  q.push_back(w[7:0]);
  endtask

  task automatic model_step();
    bit prev_avail;
`ifdef DATA_PEAK_S2_RETRIGGER_EN
    bit acc_last;
`endif
    prev_avail = m_avail;
    m_valid = 0;
    if (!m_busy) begin
      if (FastTrigger) begin
        m_busy = 1; m_T = e; q.delete(); push_word(DataIn);
      end
    end else if (e < m_T + N) begin
      push_word(DataIn);
    end else begin
`ifdef DATA_PEAK_S2_RETRIGGER_EN
      acc_last = prev_avail && DataRead && (q.size() == 1);
      if (FastTrigger && !acc_last) begin
        m_T = e; q.delete(); push_word(DataIn); m_avail = 0;
        e++;
        return;
      end
`endif
      if (prev_avail && DataRead) begin
        m_out = q.pop_front();
        m_valid = 1;
      end
      m_avail = (q.size() > 0);
      if (q.size() == 0) m_busy = 0;
    end
    e++;
  endtask

  task automatic tick();
    @(posedge SysClk);
    model_step();
    @(negedge SysClk);
    check("avail", {31'd0, DataAvailable}, {31'd0, m_avail});
    check("valid", {31'd0, DataValid}, {31'd0, m_valid});
    check("dout", {24'd0, DataOut}, {24'd0, m_out});
    if (DataValid) got.push_back(DataOut);
  endtask

  typedef struct {
    logic [31:0] din;
    bit          ramp;
    int unsigned rdmode;   // 0 continuous, 1 toggling, 2 random
    logic [7:0]  exp0, exp1, exp2, exp3;
  } vec_t;

  vec_t tbl[4];

  task automatic run_burst(input vec_t v, input string tag);
    logic [7:0] rv;
    bit tog;
    int lat;
    rv = '0; tog = 0; lat = -1;
    got.delete();
    DataIn = v.ramp ? {4{rv}} : v.din;
    FastTrigger = 1'b1;
    DataRead = 1'b0;
    tick();
    FastTrigger = 1'b0;
    for (int c = 1; c <= 1000; c++) begin
      rv = rv + 8'd1;
      if (v.ramp) DataIn = {4{rv}};
      tog = ~tog;
      case (v.rdmode)
        0:       DataRead = DataAvailable;
        1:       DataRead = DataAvailable & tog;
        default: DataRead = 1'($urandom_range(0, 1));
      endcase
      tick();
      if (DataAvailable && lat < 0) lat = c;
      if (got.size() >= NB && !DataAvailable) break;
    end
    DataRead = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'(N));
    check({tag, "_strobes"}, 32'(got.size()), 32'(NB));
    if (got.size() >= 4) begin
      check({tag, "_b0"}, {24'd0, got[0]}, {24'd0, v.exp0});
      check({tag, "_b1"}, {24'd0, got[1]}, {24'd0, v.exp1});
      check({tag, "_b2"}, {24'd0, got[2]}, {24'd0, v.exp2});
      check({tag, "_b3"}, {24'd0, got[3]}, {24'd0, v.exp3});
    end
  endtask

  initial begin
    tbl[0] = '{din: 32'h0, ramp: 1'b1, rdmode: 0, exp0: 8'h00, exp1: 8'h00, exp2: 8'h00, exp3: 8'h00};
    tbl[1] = '{din: 32'hA1B2C3D4, ramp: 1'b0, rdmode: 0, exp0: 8'hA1, exp1: 8'hB2, exp2: 8'hC3, exp3: 8'hD4};
    tbl[2] = '{din: 32'hA1B2C3D4, ramp: 1'b0, rdmode: 1, exp0: 8'hA1, exp1: 8'hB2, exp2: 8'hC3, exp3: 8'hD4};
    tbl[3] = '{din: 32'h12345678, ramp: 1'b0, rdmode: 2, exp0: 8'h12, exp1: 8'h34, exp2: 8'h56, exp3: 8'h78};

    model_reset();
    e = 0;
    repeat (3) @(negedge SysClk);
    check("rst_avail", {31'd0, DataAvailable}, 32'd0);
    check("rst_valid", {31'd0, DataValid}, 32'd0);
    check("rst_dout", {24'd0, DataOut}, 32'd0);
    Reset_n = 1'b1;

    DataIn = 32'h01010101;
    repeat (100) tick();

    for (int i = 0; i < 4; i++) begin
      run_burst(tbl[i], $sformatf("vec%0d", i));
      if (i == 0 && got.size() == NB) begin
        check("ramp_b4", {24'd0, got[4]}, 32'h01);
        check("ramp_last", {24'd0, got[NB-1]}, 32'(N - 1));
      end
      repeat (3) tick();
    end

    // Second trigger after 10 bytes have been read.
    begin
      logic [7:0] rv;
      rv = '0;
      got.delete();
      DataIn = {4{rv}};
      FastTrigger = 1'b1;
      tick();
      FastTrigger = 1'b0;
      for (int c = 0; c < 200 && got.size() < 10; c++) begin
        rv = rv + 8'd1;
        DataIn = {4{rv}};
        DataRead = DataAvailable;
        tick();
      end
      check("retrig_pre", 32'(got.size()), 32'd10);
      DataIn = 32'hDEADBEEF;
      FastTrigger = 1'b1;
      DataRead = DataAvailable;
      tick();
      FastTrigger = 1'b0;
`ifdef DATA_PEAK_S2_RETRIGGER_EN
      check("retrig_avail", {31'd0, DataAvailable}, 32'd0);
      check("retrig_valid", {31'd0, DataValid}, 32'd0);
      got.delete();
`else
      check("retrig_avail", {31'd0, DataAvailable}, 32'd1);
`endif
      for (int c = 0; c < 1000; c++) begin
        DataRead = DataAvailable;
        tick();
        if (got.size() >= NB && !DataAvailable) break;
      end
      DataRead = 1'b0;
      check("retrig_count", 32'(got.size()), 32'(NB));
      if (got.size() == NB) begin
`ifdef DATA_PEAK_S2_RETRIGGER_EN
        check("retrig_b0", {24'd0, got[0]}, 32'hDE);
        check("retrig_b1", {24'd0, got[1]}, 32'hAD);
`else
        check("retrig_b10", {24'd0, got[10]}, 32'h02);
        check("retrig_last", {24'd0, got[NB-1]}, 32'(N - 1));
`endif
      end
      repeat (3) tick();
    end

    // Reset pulse in the middle of a capture.
    DataIn = 32'h55AA55AA;
    FastTrigger = 1'b1;
    tick();
    FastTrigger = 1'b0;
    repeat (5) tick();
    Reset_n = 1'b0;
    #1;
    model_reset();
    check("midrst_avail", {31'd0, DataAvailable}, 32'd0);
    check("midrst_valid", {31'd0, DataValid}, 32'd0);
    check("midrst_dout", {24'd0, DataOut}, 32'd0);
    #1 Reset_n = 1'b1;
    repeat (2) tick();
    run_burst(tbl[0], "postrst");

    // Randomised traffic, including triggers at arbitrary times.
    for (int c = 0; c < 3000; c++) begin
      FastTrigger = ($urandom_range(0, 49) == 0);
      DataIn = $urandom;
      DataRead = 1'($urandom_range(0, 1));
      tick();
    end
    FastTrigger = 1'b0;
    for (int c = 0; c < 400 && m_busy; c++) begin
      DataRead = 1'b1;
      tick();
    end
    DataRead = 1'b0;
    check("drain_avail", {31'd0, DataAvailable}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_peak_stage2_buffer.md
# data_peak_stage2_buffer

Trigger-initiated capture buffer in the data-peak path. On a `FastTrigger` pulse it stores a fixed-length burst of 32-bit sample words, four packed 8-bit samples per word. It then offers the burst to the downstream reader one byte at a time through a registered read/valid handshake. It sits between the ADC sample aggregation (stage 1) and the system-side readout logic.

## Interface
- `CAPTURE_WORDS`, default 16: number of 32-bit words captured per trigger (power of two, 2..256).
- `SysClk`  input  1: single clock for capture and readout; all logic rises on this edge.
- `Reset_n`  input  1: reset, asynchronous, active-low.
- `DataIn`  input  32: four 8-bit samples; `[31:24]` is the oldest sample, `[7:0]` the newest.
- `FastTrigger`  input  1: capture start request, level sampled each clock.
- `DataRead`  input  1: reader pops one byte; honoured only while `DataAvailable`=1.
- `DataAvailable`  output  1: unread captured bytes exist (registered).
- `DataValid`  output  1: one-cycle strobe; `DataOut` holds a new byte.
- `DataOut`  output  8: byte output (registered).

## Operation
- The block has three states:
  - IDLE: waits for a trigger.
  - CAPTURE: writes `DataIn` into word RAM at `wr_ptr`.
  - READOUT: serves bytes to the reader.
- IDLE → CAPTURE when `FastTrigger`=1. The `DataIn` value in the trigger cycle is stored as word 0.
- CAPTURE stores one word per clock for `CAPTURE_WORDS` consecutive clocks, with no gaps. After the last write it moves to READOUT. `FastTrigger` is ignored during CAPTURE.
- READOUT:
  - Byte index `rd_idx` runs from 0 to 4·`CAPTURE_WORDS`−1.
  - Word = `rd_idx[..:2]`.
  - Byte order within a word is `[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`.
  - Each accepted read (`DataRead`=1 while `DataAvailable`=1) advances `rd_idx` by 1.
  - When the final byte is accepted, the block returns to IDLE.
- Without the macro, `FastTrigger` is ignored in READOUT.
- `DataRead` while `DataAvailable`=0 is a no-op: no strobe, no pointer change.
- Pointer widths are $clog2(`CAPTURE_WORDS`) for words and +2 bits for bytes. There is no wrap-around within a burst.

## Timing
- Reset values:
  - `DataAvailable`=0, `DataValid`=0, `DataOut`=8'h00.
  - State is IDLE and both pointers are 0.
  - RAM contents are not reset.
- Trigger is seen at edge T. Words are written at edges T … T+N−1, where N=`CAPTURE_WORDS`. `DataAvailable` rises after edge T+N.
- Read latency is 1 clock: `DataRead` sampled at edge k produces `DataOut`/`DataValid` after edge k. `DataValid` is high for exactly that one cycle per accepted read.
- Back-to-back reads are supported, one byte per clock, with `DataRead` held high.
- `DataAvailable` falls after the same edge that presents the final byte, i.e. with that byte's `DataValid`.
- A trigger arriving in the same cycle the last byte is accepted is ignored. A new capture needs a trigger sampled in IDLE.
- `DataOut` holds its last value when `DataValid`=0.
- `Reset_n` asserted mid-capture or mid-readout aborts immediately to the reset values. Data not yet read is lost.

## Configuration
- `DATA_PEAK_S2_RETRIGGER_EN`:
  - Defined: `FastTrigger`=1 during READOUT discards any unread bytes. `DataAvailable` drops after that edge, with no `DataValid` for a read in that cycle. The block enters CAPTURE with the trigger-cycle word as word 0.
  - Undefined: READOUT ignores triggers until the buffer is drained.

## Structure
- Shared package `data_peak_pkg`:
  - State enum (`DP_IDLE`, `DP_CAPTURE`, `DP_READOUT`).
  - `DP_SAMPLE_W`=8.
  - `DP_SAMPLES_PER_WORD`=4.
  - `DP_WORD_W`=32.
- Sub-module `data_peak_word_ram`: `CAPTURE_WORDS`×32 simple dual-port RAM with one write port and a registered read port. The byte mux and the FSM live in the top.

## Test plan
- Reset, then hold `DataIn`=32'h01010101, no trigger, for 100 clocks → `DataAvailable`=0, `DataValid`=0, `DataOut`=0 throughout.
- Ramp each byte lane with the same value (reset on trigger, +1 per clock), single-clock trigger, N=16 → `DataAvailable` rises 16 clocks after the trigger. Reads with `DataRead` registered from `DataAvailable` return bytes 00,00,00,00,01,01,01,01 … 0F×4. That is 64 `DataValid` strobes, after which `DataAvailable`=0.
- `DataIn`=32'hA1B2C3D4 constant, capture, read → byte stream repeats A1,B2,C3,D4.
- Read with `DataRead` toggling every other clock → `DataValid` only on accepted reads, same byte order, no byte skipped or duplicated.
- Second trigger mid-readout (after 10 bytes):
  - Macro undefined → remaining 54 bytes are unaffected.
  - Macro defined → `DataAvailable` drops, and a fresh burst begins with the trigger-cycle word.
- `Reset_n` pulse during CAPTURE → outputs go to the reset values at once. A subsequent trigger yields a complete, correct 64-byte burst.
